sensor_packet_spi_master: RTL and testbench

SPI master (mode 0, MSB first) that serializes one sensor sample into a 16-byte packet and drives it onto an SPI link as the transmitting end. The receiving end is the FPGA's Arduino-side SPI slave.
- Used in loopback/self-test builds to drive that slave's inputs from FPGA fabric.
- Also used in bridge builds that forward sensor data to a downstream FPGA.
- Accepts a sample via valid/ready handshake, latches it, and emits exactly one chip-select-framed packet per accepted sample.

---
 rtl/sensor_packet_spi_master.sv | 170 +++++++++++++++++
 tb/tb_sensor_packet_spi_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_packet_spi_master.sv
// Mode-0 SPI master: latches one sensor sample and sends it as a 16-byte, cs_n-framed packet.
// Define PKT_CHECKSUM_EN to make byte15 the XOR of bytes 0-14 (otherwise byte15 is 8'h00).
//
// state    | meaning
// ST_IDLE  | cs_n high, pkt_ready high, waiting for pkt_valid
// ST_SETUP | cs_n low, bit 127 on sdo, waiting out the setup time before the first sck rise
// ST_SHIFT | sck toggling every CLK_DIV cycles, sdo updated on falling edges
// ST_HOLD  | sck low, cs_n still low for CS_HOLD cycles
// ST_GAP   | cs_n high for GAP cycles before the next packet may be accepted
module sensor_packet_spi_master #(
  parameter int CLK_DIV  = 120,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        quat_valid,
  input  logic        gyro_valid,
  input  logic [15:0] quat_w,
  input  logic [15:0] quat_x,
  input  logic [15:0] quat_y,
  input  logic [15:0] quat_z,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic        spi_sck,
  output logic        spi_sdo,
  output logic        spi_cs_n,
  output logic        busy,
  output logic        pkt_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // The setup window also has to cover the first low half-period of sck.
  localparam int SETUP_LEN = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam logic [11:0] SETUP_LOAD = 12'(SETUP_LEN - 1);
  localparam logic [11:0] HALF_LOAD  = 12'(CLK_DIV - 1);
  localparam logic [11:0] HOLD_LOAD  = 12'(CS_HOLD - 1);
  localparam logic [11:0] GAP_LOAD   = 12'(GAP - 1);

  state_t        state;
  logic [11:0]   half_cnt;
  logic [6:0]    bit_cnt;
  logic [127:0]  shreg;
  logic [127:0]  pkt_word;

  assign pkt_word = {4'hA, 2'b00, quat_valid, gyro_valid,
                     quat_w, quat_x, quat_y, quat_z,
                     gyro_x, gyro_y, gyro_z, 8'h00};

`ifdef PKT_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [119:0] data);
    logic [7:0]   acc;
    logic [119:0] rest;
    acc  = '0;
    rest = data;
    for (int i = 0; i < 15; i++) begin
      acc  = acc ^ rest[7:0];
      rest = rest >> 8;
    end
    return acc;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      spi_sck   <= 1'b0;
      spi_sdo   <= 1'b0;
      spi_cs_n  <= 1'b1;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ready <= 1'b1;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pkt_valid) begin
            shreg     <= pkt_word;
            spi_sdo   <= pkt_word[127];
            spi_cs_n  <= 1'b0;
            busy      <= 1'b1;
            pkt_ready <= 1'b0;
            half_cnt  <= SETUP_LOAD;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (half_cnt == 12'd0) begin
`ifdef PKT_CHECKSUM_EN
            shreg[7:0] <= xor_bytes(shreg[127:8]);
`endif
            spi_sck  <= 1'b1;
            bit_cnt  <= '0;
            half_cnt <= HALF_LOAD;
            state    <= ST_SHIFT;
          end else begin
            half_cnt <= half_cnt - 12'd1;
          end
        end

        ST_SHIFT: begin
          if (half_cnt != 12'd0) begin
            half_cnt <= half_cnt - 12'd1;
          end else if (!spi_sck) begin
            spi_sck  <= 1'b1;
            half_cnt <= HALF_LOAD;
          end else if (bit_cnt == 7'd127) begin
            spi_sck  <= 1'b0;
            spi_sdo  <= 1'b0;
            half_cnt <= HOLD_LOAD;
            state    <= ST_HOLD;
          end else begin
            // Next bit goes out on the falling edge so it is stable at the next rise.
            spi_sck  <= 1'b0;
            spi_sdo  <= shreg[126];
            shreg    <= {shreg[126:0], 1'b0};
            bit_cnt  <= bit_cnt + 7'd1;
            half_cnt <= HALF_LOAD;
          end
        end

        ST_HOLD: begin
          if (half_cnt == 12'd0) begin
            spi_cs_n <= 1'b1;
            pkt_done <= 1'b1;
            half_cnt <= GAP_LOAD;
            state    <= ST_GAP;
          end else begin
            half_cnt <= half_cnt - 12'd1;
          end
        end

        ST_GAP: begin
          if (half_cnt == 12'd0) begin
            busy      <= 1'b0;
            pkt_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            half_cnt <= half_cnt - 12'd1;
          end
        end

        default: begin
          spi_sck   <= 1'b0;
          spi_sdo   <= 1'b0;
          spi_cs_n  <= 1'b1;
          busy      <= 1'b0;
          pkt_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// Bench for sensor_packet_spi_master: timing/packet model driven by accept edges, SPI slave capture.
module tb_sensor_packet_spi_master;

  localparam int CLK_DIV   = 2;
  localparam int CS_SETUP  = 4;
  localparam int CS_HOLD   = 4;
  localparam int GAP       = 16;
  localparam int SETUP_LEN = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int LAST_FALL = SETUP_LEN + 2 * CLK_DIV * 127 + CLK_DIV;
  localparam int CS_RISE   = LAST_FALL + CS_HOLD;
  localparam int READY_AT  = CS_RISE + GAP;

`ifdef PKT_CHECKSUM_EN
  localparam logic [7:0] TRL1 = 8'h84;
  localparam logic [7:0] TRL2 = 8'hA2;
`else
  localparam logic [7:0] TRL1 = 8'h00;
  localparam logic [7:0] TRL2 = 8'h00;
`endif
  localparam logic [127:0] PKT1 = {40'hA312340001, 80'h0, TRL1};
  localparam logic [127:0] PKT2 = {24'hA10102, 96'h0, TRL2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic        quat_valid = 1'b0;
  logic        gyro_valid = 1'b0;
  logic [15:0] quat_w = '0, quat_x = '0, quat_y = '0, quat_z = '0;
  logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic        spi_sck, spi_sdo, spi_cs_n, busy, pkt_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sensor_packet_spi_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid),
    .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_cs_n(spi_cs_n),
    .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] build_pkt();
    logic [127:0] p;
    logic [127:0] rest;
    logic [7:0]   t;
    p = {4'hA, 2'b00, quat_valid, gyro_valid, quat_w, quat_x, quat_y, quat_z,
         gyro_x, gyro_y, gyro_z, 8'h00};
    t = 8'h00;
`ifdef PKT_CHECKSUM_EN
    rest = p >> 8;
    for (int i = 0; i < 15; i++) begin
      t    = t ^ rest[7:0];
      rest = rest >> 8;
    end
`else
    rest = p;
`endif
    p[7:0] = t | (rest[7:0] & 8'h00);
    return p;
  endfunction

  // Model: position d (clock edges since the accept edge) fully determines every output.
  logic         m_active = 1'b0;
  int           m_d = 0;
  logic [127:0] m_pkt = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_d++;
      if (m_d == READY_AT) m_active = 1'b0;
    end else if (pkt_valid) begin
      m_active = 1'b1;
      m_d      = 0;
      m_pkt    = build_pkt();
    end
  end

  int   got_done = 0;
  int   exp_done = 0;
  int   hi_run = 0;
  logic b2b = 1'b0;
  logic had_pkt = 1'b0;

  always @(negedge clk) begin
    logic         e_cs, e_sck, e_sdo, e_busy, e_rdy, e_done;
    logic [127:0] sh;
    int           idx;
    if (!rst_n || !m_active) begin
      e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b0;
    end else begin
      e_cs   = (m_d >= CS_RISE);
      e_sck  = (m_d >= SETUP_LEN) && (m_d < LAST_FALL) &&
               (((m_d - SETUP_LEN) % (2 * CLK_DIV)) < CLK_DIV);
      if (m_d >= LAST_FALL) begin
        e_sdo = 1'b0;
      end else begin
        idx   = (m_d < SETUP_LEN + CLK_DIV) ? 0 : (m_d - SETUP_LEN - CLK_DIV) / (2 * CLK_DIV) + 1;
        sh    = m_pkt << idx;
        e_sdo = sh[127];
      end
      e_busy = 1'b1;
      e_rdy  = 1'b0;
      e_done = (m_d == CS_RISE);
    end
    check_b("cs_n", spi_cs_n, e_cs);
    check_b("sck", spi_sck, e_sck);
    check_b("sdo", spi_sdo, e_sdo);
    check_b("busy", busy, e_busy);
    check_b("pkt_ready", pkt_ready, e_rdy);
    check_b("pkt_done", pkt_done, e_done);
    if (pkt_done) got_done++;
    if (e_done) exp_done++;
    if (spi_cs_n) begin
      hi_run++;
    end else begin
      if (b2b && had_pkt && hi_run > 0) check_i("b2b_gap", hi_run, GAP + 1);
      if (b2b) had_pkt = 1'b1;
      hi_run = 0;
    end
  end

  // Slave: samples sdo on sck rising, checks the frame when cs_n rises.
  logic [127:0] cap = '0;
  logic [127:0] last_cap = '0;
  int           cap_n = 0;
  int           pkts_rx = 0;

  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      if (rst_n) begin
        check_i("slave_edges", cap_n, 128);
        check_v("slave_data", cap, m_pkt);
        last_cap = cap;
        pkts_rx++;
      end
      cap   = '0;
      cap_n = 0;
    end else begin
      cap = {cap[126:0], spi_sdo};
      cap_n++;
    end
  end

  task automatic set_fields(input logic qv, input logic gv, input logic [15:0] w, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] z, input logic [15:0] gx,
                            input logic [15:0] gy, input logic [15:0] gz);
    quat_valid = qv; gyro_valid = gv;
    quat_w = w; quat_x = x; quat_y = y; quat_z = z;
    gyro_x = gx; gyro_y = gy; gyro_z = gz;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!pkt_ready && k < 2 * READY_AT) begin
      @(negedge clk);
      k++;
    end
    check_b(name, pkt_ready, 1'b1);
  endtask

  task automatic wait_rx(input string name, input int target);
    int k = 0;
    while (pkts_rx < target && k < 2 * READY_AT) begin
      @(negedge clk);
      k++;
    end
    check_i(name, pkts_rx, target);
  endtask

  task automatic send_one();
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, t0, t1, t_fall, t_cs, base, done_before;
    logic prev_sck;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_b("rst_cs_n", spi_cs_n, 1'b1);
    check_b("rst_sck", spi_sck, 1'b0);
    check_b("rst_ready", pkt_ready, 1'b1);
    repeat (100) @(negedge clk);

    // Packet 1 with edge-by-edge timing
    set_fields(1'b1, 1'b1, 16'h1234, 16'h0001, '0, '0, '0, '0, '0);
    send_one();
    t0 = cyc;
    check_b("cs_low_after_accept", spi_cs_n, 1'b0);
    check_b("ready_low_after_accept", pkt_ready, 1'b0);
    k = 0;
    while (!spi_sck && k < 100) begin @(negedge clk); k++; end
    check_i("first_rise_delay", cyc - t0, 4);
    t1 = cyc; k = 0;
    while (spi_sck && k < 100) begin @(negedge clk); k++; end
    check_i("sck_high_cycles", cyc - t1, 2);
    t1 = cyc; k = 0;
    while (!spi_sck && k < 100) begin @(negedge clk); k++; end
    check_i("sck_low_cycles", cyc - t1, 2);
    prev_sck = spi_sck; t_fall = cyc; k = 0;
    while (!spi_cs_n && k < 2 * READY_AT) begin
      @(negedge clk);
      k++;
      if (!spi_sck && prev_sck) t_fall = cyc;
      prev_sck = spi_sck;
    end
    check_i("cs_rise_after_last_fall", cyc - t_fall, 4);
    check_b("pkt_done_at_cs_rise", pkt_done, 1'b1);
    t_cs = cyc; k = 0;
    while (!pkt_ready && k < 100) begin @(negedge clk); k++; end
    check_i("cs_high_cycles_to_ready", cyc - t_cs + 1, 17);
    check_v("pkt1_capture", last_cap, PKT1);
    check_i("pkt1_count", pkts_rx, 1);

    // Back-to-back with data changing every cycle
    base = pkts_rx;
    b2b = 1'b1;
    pkt_valid = 1'b1;
    k = 0;
    while (pkts_rx < base + 3 && k < 3 * READY_AT + 200) begin
      set_fields(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      k++;
    end
    pkt_valid = 1'b0;
    b2b = 1'b0;
    check_i("b2b_packets", pkts_rx - base, 3);
    wait_ready("b2b_ready");

    // Inputs forced to all ones mid-packet
    base = pkts_rx;
    set_fields(1'b0, 1'b1, 16'h0102, '0, '0, '0, '0, '0, '0);
    send_one();
    repeat (100) @(negedge clk);
    set_fields(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_rx("midchange_rx", base + 1);
    check_v("midchange_capture", last_cap, PKT2);
    wait_ready("midchange_ready");

    // Reset at bit 60, then a clean packet
    set_fields(1'b1, 1'b1, 16'h1234, 16'h0001, '0, '0, '0, '0, '0);
    send_one();
    k = 0;
    while (cap_n < 60 && k < 2 * READY_AT) begin @(negedge clk); k++; end
    check_i("reached_bit60", cap_n, 60);
    base = pkts_rx;
    done_before = got_done;
    #2 rst_n = 1'b0;
    #1;
    check_b("abort_cs_n", spi_cs_n, 1'b1);
    check_b("abort_sck", spi_sck, 1'b0);
    check_b("abort_done", pkt_done, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_i("abort_no_done", got_done, done_before);
    send_one();
    wait_rx("post_reset_rx", base + 1);
    check_v("post_reset_capture", last_cap, PKT1);
    wait_ready("post_reset_ready");

    repeat (5) @(negedge clk);
    check_i("done_vs_model", got_done, exp_done);
    check_i("done_total", got_done, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
